// File: rtl/uesprit_doa_cordic.sv
// U-ESPRIT DoA back end: picks the eigenvector of the dominant eigenvalue and
// resolves its phase atan2(y,x) with a one-rotation-per-clock vectoring CORDIC.
// Also reports eigenvalue spread as confidence and counts inputs lost while busy.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for din_valid, capture allowed
// ITER  | one CORDIC micro-rotation per clock, din_valid is dropped
// DONE  | results presented with dout_valid, capture allowed
module uesprit_doa_cordic #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 13,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_POINT = 13,
  parameter int ITERS      = 14,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIN_WIDTH-1:0]  lamb1,
  input  logic [DIN_WIDTH-1:0]  lamb2,
  input  logic [DIN_WIDTH-1:0]  eigen1_y,
  input  logic [DIN_WIDTH-1:0]  eigen2_y,
  input  logic [DIN_WIDTH-1:0]  eigen_x,
  input  logic                  din_valid,
  output logic                  busy,
  output logic [DOUT_WIDTH-1:0] angle,
  output logic [DIN_WIDTH-1:0]  confidence,
  output logic                  eig_sel,
  output logic                  degenerate,
  output logic                  dout_valid,
  output logic [DROP_WIDTH-1:0] drop_count
);

  // Fractional guard bits below the input LSB so shift truncation stays well
  // under one angle LSB even for the smallest vectors we promise accuracy on.
  localparam int GUARD_RAW = DOUT_POINT - DIN_POINT + 6;
  localparam int GUARD     = (GUARD_RAW < 0) ? 0 : GUARD_RAW;
  // Two integer headroom bits: negating the most negative input and CORDIC gain.
  localparam int XW        = DIN_WIDTH + 2 + GUARD;
  localparam int ZW        = DOUT_WIDTH + 1;
  localparam int CW        = (ITERS > 1) ? $clog2(ITERS) : 1;

  // atan(2^-i) in Q30; beyond i=9 atan(2^-i) rounds to exactly 2^(30-i).
  function automatic logic [63:0] atan_q30(input int i);
    case (i)
      0:       return 64'd843314857;
      1:       return 64'd497837830;
      2:       return 64'd263043837;
      3:       return 64'd133525159;
      4:       return 64'd67021687;
      5:       return 64'd33543515;
      6:       return 64'd16775851;
      7:       return 64'd8388438;
      8:       return 64'd4194283;
      9:       return 64'd2097149;
      default: return (i < 31) ? (64'd1 << (30 - i)) : 64'd0;
    endcase
  endfunction

  // Round a Q30 angle to the output scale.
  function automatic logic signed [ZW-1:0] to_angle(input logic [63:0] q30);
    logic [63:0] r;
    r = (q30 + (64'd1 << (29 - DOUT_POINT))) >> (30 - DOUT_POINT);
    return $signed(r[ZW-1:0]);
  endfunction

  localparam logic signed [ZW-1:0] PI_Q  = to_angle(64'd3373259426);
  localparam logic signed [ZW-1:0] NPI_Q = -PI_Q;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

  state_t                state;
  logic [CW-1:0]         iter_cnt;
  logic signed [XW-1:0]  x_r, y_r;
  logic signed [ZW-1:0]  z_r;
  logic                  sel_r, deg_r;
  logic [DIN_WIDTH-1:0]  conf_r;

  logic signed [ZW-1:0]  atan_rom [ITERS];

  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    assign atan_rom[g] = to_angle(atan_q30(g));
  end

  logic                     sel_in, deg_in;
  logic [DIN_WIDTH-1:0]     ysel;
  logic signed [DIN_WIDTH:0] diff;
  logic [DIN_WIDTH-1:0]     conf_in;
  logic signed [XW-1:0]     x_ext, y_ext, x_cap, y_cap;
  logic signed [ZW-1:0]     z_cap;
  logic signed [XW-1:0]     xs, ys, x_nx, y_nx;
  logic signed [ZW-1:0]     z_nx;
  logic [DOUT_WIDTH-1:0]    angle_nx;

  // Capture path: eigenvector selection, confidence and quadrant pre-rotation.
  always_comb begin
    sel_in  = $signed(lamb2) > $signed(lamb1);
    ysel    = sel_in ? eigen2_y : eigen1_y;
    diff    = sel_in ? ($signed({lamb2[DIN_WIDTH-1], lamb2}) - $signed({lamb1[DIN_WIDTH-1], lamb1}))
                     : ($signed({lamb1[DIN_WIDTH-1], lamb1}) - $signed({lamb2[DIN_WIDTH-1], lamb2}));
    conf_in = (diff[DIN_WIDTH] | diff[DIN_WIDTH-1]) ? {1'b0, {(DIN_WIDTH-1){1'b1}}}
                                                    : diff[DIN_WIDTH-1:0];
    x_ext   = XW'($signed(eigen_x)) <<< GUARD;
    y_ext   = XW'($signed(ysel)) <<< GUARD;
    deg_in  = (eigen_x == '0) && (ysel == '0);
    if (x_ext[XW-1]) begin
      x_cap = -x_ext;
      y_cap = -y_ext;
      z_cap = y_ext[XW-1] ? NPI_Q : PI_Q;
    end else begin
      x_cap = x_ext;
      y_cap = y_ext;
      z_cap = '0;
    end
  end

  // One vectoring micro-rotation plus saturation of the accumulated angle.
  always_comb begin
    xs = x_r >>> iter_cnt;
    ys = y_r >>> iter_cnt;
    if (!y_r[XW-1]) begin
      x_nx = x_r + ys;
      y_nx = y_r - xs;
      z_nx = z_r + atan_rom[iter_cnt];
    end else begin
      x_nx = x_r - ys;
      y_nx = y_r + xs;
      z_nx = z_r - atan_rom[iter_cnt];
    end
    if (z_nx > PI_Q)       angle_nx = DOUT_WIDTH'(PI_Q);
    else if (z_nx < NPI_Q) angle_nx = DOUT_WIDTH'(NPI_Q);
    else                   angle_nx = DOUT_WIDTH'(z_nx);
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      iter_cnt   <= '0;
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      sel_r      <= 1'b0;
      deg_r      <= 1'b0;
      conf_r     <= '0;
      busy       <= 1'b0;
      angle      <= '0;
      confidence <= '0;
      eig_sel    <= 1'b0;
      degenerate <= 1'b0;
      dout_valid <= 1'b0;
      drop_count <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (state == ST_ITER) begin
        if (din_valid && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        x_r      <= x_nx;
        y_r      <= y_nx;
        z_r      <= z_nx;
        iter_cnt <= iter_cnt + 1'b1;
        if (iter_cnt == CW'(ITERS - 1)) begin
          state      <= ST_DONE;
          busy       <= 1'b0;
          dout_valid <= 1'b1;
          angle      <= deg_r ? '0 : angle_nx;
          confidence <= conf_r;
          eig_sel    <= sel_r;
          degenerate <= deg_r;
        end
      end else if (din_valid) begin
        state    <= ST_ITER;
        busy     <= 1'b1;
        iter_cnt <= '0;
        x_r      <= x_cap;
        y_r      <= y_cap;
        z_r      <= z_cap;
        sel_r    <= sel_in;
        deg_r    <= deg_in;
        conf_r   <= conf_in;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule
